// File: rtl/aes_pkg.sv
// Shared types, AES size constants, FSM encoding and the inverse-round byte transforms.
// Bytes are numbered 0..15 from the MSB; byte i sits at row i%4, column i/4.
package aes_pkg;

    typedef logic [127:0]     state_t;
    typedef logic [7:0]       byte_t;
    typedef logic [0:15][7:0] blk_t;

    localparam int unsigned NR_128 = 10;
    localparam int unsigned NR_192 = 12;
    localparam int unsigned NR_256 = 14;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_FINAL,
        S_DONE
    } fsm_t;

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic byte_t xtime(byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gmul(byte_t a, byte_t b);
        byte_t p;
        byte_t x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Row r rotates right by r columns.
    function automatic state_t inv_shift_rows(state_t s);
        blk_t a;
        blk_t r;
        a = s;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned rw = 0; rw < 4; rw++) begin
                r[rw + 4*c] = a[rw + 4*((c + 4 - rw) % 4)];
            end
        end
        return r;
    endfunction

    function automatic state_t inv_sub_bytes(state_t s);
        blk_t a;
        blk_t r;
        a = s;
        for (int unsigned i = 0; i < 16; i++) begin
            r[i] = INV_SBOX[a[i]];
        end
        return r;
    endfunction

    function automatic state_t inv_mix_columns(state_t s);
        blk_t a;
        blk_t r;
        a = s;
        for (int unsigned c = 0; c < 4; c++) begin
            r[4*c+0] = gmul(a[4*c], 8'h0e) ^ gmul(a[4*c+1], 8'h0b) ^ gmul(a[4*c+2], 8'h0d) ^ gmul(a[4*c+3], 8'h09);
            r[4*c+1] = gmul(a[4*c], 8'h09) ^ gmul(a[4*c+1], 8'h0e) ^ gmul(a[4*c+2], 8'h0b) ^ gmul(a[4*c+3], 8'h0d);
            r[4*c+2] = gmul(a[4*c], 8'h0d) ^ gmul(a[4*c+1], 8'h09) ^ gmul(a[4*c+2], 8'h0e) ^ gmul(a[4*c+3], 8'h0b);
            r[4*c+3] = gmul(a[4*c], 8'h0b) ^ gmul(a[4*c+1], 8'h0d) ^ gmul(a[4*c+2], 8'h09) ^ gmul(a[4*c+3], 8'h0e);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_inv_round_seq_if.sv
// Ciphertext-in / plaintext-out handshake plus the round-key lookup toward the key store.
interface aes_inv_round_seq_if;
    import aes_pkg::*;

    logic       in_valid;
    logic       in_ready;
    state_t     in_data;
    logic [3:0] key_idx;
    state_t     round_key;
    logic       out_valid;
    logic       out_ready;
    state_t     out_data;

    modport master (
        output in_valid, in_data, round_key, out_ready,
        input  in_ready, key_idx, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, round_key, out_ready,
        output in_ready, key_idx, out_valid, out_data
    );

endinterface

// File: rtl/inv_round_dp.sv
// Combinational inverse-round datapath; is_final skips InvMixColumns for the last round.
module inv_round_dp
    import aes_pkg::*;
(
    input  state_t st,
    input  state_t round_key,
    input  logic   is_final,
    output state_t nxt
);

    state_t ark;

    always_comb begin
        ark = inv_sub_bytes(inv_shift_rows(st)) ^ round_key;
        nxt = is_final ? ark : inv_mix_columns(ark);
    end

endmodule

// File: rtl/aes_inv_round_seq.sv
// Iterative AES inverse cipher: one round per clock, a single block in flight.
module aes_inv_round_seq
    import aes_pkg::*;
#(
    parameter int unsigned NR = NR_128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_inv_round_seq_if.slave   bus
);

    if (NR != NR_128 && NR != NR_192 && NR != NR_256) begin : g_bad_nr
        $error("aes_inv_round_seq: NR must be 10, 12 or 14");
    end

    localparam logic [3:0] NR_IDX   = 4'(NR);
    localparam logic [3:0] RC_START = 4'(NR - 1);

    fsm_t       state_q, state_d;
    logic [3:0] rc_q, rc_d;
    state_t     st_q, st_d;
    state_t     out_data_q, out_data_d;
    state_t     dp_nxt;
    logic       ready;

    inv_round_dp u_dp (
        .st        (st_q),
        .round_key (bus.round_key),
        .is_final  (state_q == S_FINAL),
        .nxt       (dp_nxt)
    );

    always_comb begin
        state_d       = state_q;
        rc_d          = rc_q;
        st_d          = st_q;
        out_data_d    = out_data_q;
        ready         = 1'b0;
        bus.out_valid = 1'b0;
        bus.key_idx   = '0;
        case (state_q)
            S_IDLE: begin
                // Gated by rst_n so the source never sees ready while reset is held.
                ready       = rst_n;
                bus.key_idx = NR_IDX;
                if (bus.in_valid && ready) begin
                    st_d    = bus.in_data ^ bus.round_key;
                    rc_d    = RC_START;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                bus.key_idx = rc_q;
                st_d        = dp_nxt;
                if (rc_q == 4'd1) state_d = S_FINAL;
                else              rc_d    = rc_q - 4'd1;
            end
            S_FINAL: begin
                st_d       = dp_nxt;
                out_data_d = dp_nxt;
                state_d    = S_DONE;
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.in_ready = ready;
    assign bus.out_data = out_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rc_q       <= '0;
            st_q       <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rc_q       <= rc_d;
            st_q       <= st_d;
            out_data_q <= out_data_d;
        end
    end

endmodule

// File: tb/tb_aes_inv_round_seq.sv
// Directed bench: AES-128 and AES-256 sequencers fed from a bench-side key-schedule model.
module tb_aes_inv_round_seq;
    import aes_pkg::*;

    localparam state_t CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam state_t CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam state_t PT     = 128'h00112233445566778899aabbccddeeff;
    localparam state_t ISTART = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam state_t CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam state_t PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KB   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic key_sel;
    state_t rk_a   [0:15];
    state_t rk_alt [0:15];
    state_t rk_b   [0:15];
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    aes_inv_round_seq_if bus_a ();
    aes_inv_round_seq_if bus_b ();

    aes_inv_round_seq #(.NR(NR_128)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    aes_inv_round_seq #(.NR(NR_256)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    assign bus_a.round_key = key_sel ? rk_alt[bus_a.key_idx] : rk_a[bus_a.key_idx];
    assign bus_b.round_key = rk_b[bus_b.key_idx];

    function automatic logic [7:0] m_xtime(logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m_mul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = m_xtime(x);
        end
        return p;
    endfunction

    // Forward S-box from first principles: x^254 followed by the affine map.
    function automatic logic [7:0] m_sbox(logic [7:0] x);
        logic [7:0] v = 8'h01;
        for (int i = 0; i < 254; i++) v = m_mul(v, x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] m_subword(logic [31:0] w);
        return {m_sbox(w[31:24]), m_sbox(w[23:16]), m_sbox(w[15:8]), m_sbox(w[7:0])};
    endfunction

    function automatic state_t m_round_key(int unsigned nk, logic [255:0] key, int unsigned r);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int unsigned i = 0; i < 60; i++) begin
            if (i < nk) begin
                w[i] = key[255 - 32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t = m_subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                    rcon = m_xtime(rcon);
                end else if (nk > 6 && i % nk == 4) begin
                    t = m_subword(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned n;
        logic [3:0] idx_log [0:15];

        for (int unsigned r = 0; r < 16; r++) begin
            rk_a[r]   = (r <= 10) ? m_round_key(4, K128, r) : '0;
            rk_alt[r] = (r <= 10) ? m_round_key(4, KB, r)   : '0;
            rk_b[r]   = (r <= 14) ? m_round_key(8, K256, r) : '0;
            idx_log[r] = 4'hf;
        end
        key_sel = 1'b0;
        bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;

        #1 rst_n = 1'b0;
        #2;
        chk("rst_in_ready",  128'(bus_a.in_ready),  128'(0));
        chk("rst_out_valid", 128'(bus_a.out_valid), 128'(0));
        chk("rst_out_data",  bus_a.out_data,        128'(0));
        chk("rst_key_idx",   128'(bus_a.key_idx),   128'(10));
        chk("rst_state",     128'(dut_a.state_q),   128'(S_IDLE));
        chk("rst_b_valid",   128'(bus_b.out_valid), 128'(0));
        tick();
        tick();
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("release_in_ready", 128'(bus_a.in_ready), 128'(1));

        // AES-128 latency, key_idx walk and first-round state
        bus_a.in_data  = CT128;
        bus_a.in_valid = 1'b1;
        chk("t1_accept_key_idx", 128'(bus_a.key_idx), 128'(10));
        tick();
        bus_a.in_valid = 1'b0;
        bus_a.in_data  = '1;
        chk("t2_st_after_accept", dut_a.st_q, ISTART);
        chk("t1_busy_in_ready", 128'(bus_a.in_ready), 128'(0));
        n = 0;
        while (!bus_a.out_valid && n < 40) begin
            if (n < 16) idx_log[n] = bus_a.key_idx;
            tick();
            n++;
        end
        // Latency counts the accept cycle as the first one.
        chk("t1_latency", 128'(n + 1), 128'(11));
        for (int unsigned j = 0; j < 10; j++)
            chk("t2_key_idx", 128'(idx_log[j]), 128'((j < 9) ? 9 - j : 0));
        chk("t1_plaintext", bus_a.out_data, PT);

        // Backpressure in DONE with a competing in_valid
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = CT_B;
        for (int unsigned k = 0; k < 5; k++) begin
            tick();
            chk("t4_out_valid", 128'(bus_a.out_valid), 128'(1));
            chk("t4_out_data",  bus_a.out_data,        PT);
            chk("t4_in_ready",  128'(bus_a.in_ready),  128'(0));
        end
        chk("t4_st_held", dut_a.st_q, PT);
        bus_a.in_valid  = 1'b0;
        bus_a.out_ready = 1'b1;
        tick();
        bus_a.out_ready = 1'b0;
        chk("t4_valid_fall", 128'(bus_a.out_valid), 128'(0));
        chk("t4_data_hold",  bus_a.out_data,        PT);
        chk("t4_ready_back", 128'(bus_a.in_ready),  128'(1));

        // Back-to-back: second block uses the FIPS-197 appendix B key
        bus_a.in_data   = CT128;
        bus_a.in_valid  = 1'b1;
        bus_a.out_ready = 1'b1;
        tick();
        n = 0;
        while (!bus_a.out_valid && n < 40) begin tick(); n++; end
        chk("t5_pt1_valid", 128'(bus_a.out_valid), 128'(1));
        chk("t5_pt1", bus_a.out_data, PT);
        key_sel       = 1'b1;
        bus_a.in_data = CT_B;
        tick();
        chk("t5_gap_in_ready", 128'(bus_a.in_ready), 128'(1));
        tick();
        chk("t5_second_accept", 128'(bus_a.in_ready), 128'(0));
        chk("t5_st2", dut_a.st_q, CT_B ^ rk_alt[10]);
        bus_a.in_valid = 1'b0;
        n = 0;
        while (!bus_a.out_valid && n < 40) begin tick(); n++; end
        chk("t5_pt2", bus_a.out_data, PT_B);
        tick();
        bus_a.out_ready = 1'b0;
        key_sel         = 1'b0;

        // AES-256
        bus_b.in_data  = CT256;
        bus_b.in_valid = 1'b1;
        chk("t3_accept_key_idx", 128'(bus_b.key_idx), 128'(14));
        tick();
        bus_b.in_valid = 1'b0;
        n = 0;
        while (!bus_b.out_valid && n < 40) begin tick(); n++; end
        chk("t3_latency", 128'(n + 1), 128'(15));
        chk("t3_plaintext", bus_b.out_data, PT);
        bus_b.out_ready = 1'b1;
        tick();
        bus_b.out_ready = 1'b0;

        // Asynchronous reset during round 5
        bus_a.in_data  = CT128;
        bus_a.in_valid = 1'b1;
        tick();
        bus_a.in_valid = 1'b0;
        repeat (4) tick();
        chk("t6_round5_key_idx", 128'(bus_a.key_idx), 128'(5));
        #3 rst_n = 1'b0;
        #1;
        chk("t6_out_valid", 128'(bus_a.out_valid), 128'(0));
        chk("t6_out_data",  bus_a.out_data,        128'(0));
        chk("t6_in_ready",  128'(bus_a.in_ready),  128'(0));
        chk("t6_key_idx",   128'(bus_a.key_idx),   128'(10));
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("t6_release_in_ready", 128'(bus_a.in_ready), 128'(1));
        bus_a.in_valid = 1'b1;
        tick();
        bus_a.in_valid = 1'b0;
        n = 0;
        while (!bus_a.out_valid && n < 40) begin tick(); n++; end
        chk("t6_latency", 128'(n + 1), 128'(11));
        chk("t6_plaintext", bus_a.out_data, PT);
        bus_a.out_ready = 1'b1;
        tick();
        bus_a.out_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
